// File: rtl/imem_pkg.sv
// Shared constants and the response record for the instruction fetch unit.
package imem_pkg;

  localparam logic [31:0] NOP_INSTR          = 32'h0000_0000;
  localparam int          DEFAULT_DEPTH      = 256;
  localparam int          DEFAULT_FIFO_DEPTH = 4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } fetch_rsp_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous response FIFO with occupancy count and a synchronous clear.
module ifetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop & (count != '0);
  assign do_push = push & ((count != (PW+1)'(DEPTH)) | do_pop);

  // Empty reads as zero so the outputs are clean during and after reset.
  assign pop_data = (count != '0) ? store[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push && !clear) store[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/imem_fetch.sv
// Two-stage instruction fetch with credit-based response buffering.
// Define IMEM_OOR_TRAP_EN to trap addresses >= DEPTH (rsp_err, NOP) instead of wrapping.
module imem_fetch
  import imem_pkg::*;
#(
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  input  logic        flush,
  output logic        rsp_valid,
  output logic [31:0] rsp_instr,
  output logic [31:0] rsp_addr,
  output logic        rsp_err,
  input  logic        rsp_ready,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   mem [DEPTH];
  logic          a_valid;
  logic [31:0]   a_addr;
  logic          b_valid;
  logic [31:0]   b_addr;
  logic [31:0]   b_read;
  logic [31:0]   b_instr;
  logic          b_err;
  logic          read_en;
  logic          accept;
  logic          pop;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   in_flight;
  fetch_rsp_t    push_rsp;
  fetch_rsp_t    head_rsp;
  logic          unused_wr_hi;

  assign unused_wr_hi = ^wr_addr[31:AW];

  // Every accepted request holds a FIFO slot until popped, so the buffer can never overflow.
  assign in_flight = {1'b0, fifo_count} + (CW+1)'(a_valid) + (CW+1)'(b_valid);
  assign req_ready = reset & ~flush & (in_flight < (CW+1)'(FIFO_DEPTH));
  assign accept    = req_valid & req_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_valid <= 1'b0;
      a_addr  <= '0;
      b_valid <= 1'b0;
      b_addr  <= '0;
    end else if (flush) begin
      a_valid <= 1'b0;
      b_valid <= 1'b0;
    end else begin
      a_valid <= accept;
      b_valid <= a_valid;
      if (accept)  a_addr <= req_addr;
      if (a_valid) b_addr <= a_addr;
    end
  end

`ifdef IMEM_OOR_TRAP_EN
  logic a_oor;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_oor <= 1'b0;
      b_err <= 1'b0;
    end else begin
      if (accept)  a_oor <= (req_addr >= 32'(DEPTH));
      if (a_valid) b_err <= a_oor;
    end
  end

  assign read_en = a_valid & ~a_oor;
  assign b_instr = b_err ? NOP_INSTR : b_read;
`else
  assign b_err   = 1'b0;
  assign read_en = a_valid;
  assign b_instr = b_read;
`endif

  // Nonblocking write and read on the same edge: a colliding read returns the old word.
  always_ff @(posedge clk) begin
    if (wr_en)   mem[wr_addr[AW-1:0]] <= wr_data;
    if (read_en) b_read <= mem[a_addr[AW-1:0]];
  end

  assign push_rsp.instr = b_instr;
  assign push_rsp.addr  = b_addr;
  assign push_rsp.err   = b_err;

  assign rsp_valid = (fifo_count != '0);
  assign pop       = rsp_valid & rsp_ready;

  ifetch_fifo #(
    .WIDTH ($bits(fetch_rsp_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .push      (b_valid & ~flush),
    .push_data (push_rsp),
    .pop       (pop),
    .pop_data  (head_rsp),
    .count     (fifo_count)
  );

  assign rsp_instr = head_rsp.instr;
  assign rsp_addr  = head_rsp.addr;
  assign rsp_err   = head_rsp.err;

endmodule

// File: tb/tb_imem_fetch.sv
// Randomized and directed bench for imem_fetch against a transaction-level reference model.
module tb_imem_fetch;

  localparam int DEPTH = 256;
  localparam int FD    = 4;
  localparam int AW    = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        flush;
  logic        rsp_valid;
  logic [31:0] rsp_instr;
  logic [31:0] rsp_addr;
  logic        rsp_err;
  logic        rsp_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  imem_fetch #(.DEPTH(DEPTH), .FIFO_DEPTH(FD)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .flush     (flush),
    .rsp_valid (rsp_valid),
    .rsp_instr (rsp_instr),
    .rsp_addr  (rsp_addr),
    .rsp_err   (rsp_err),
    .rsp_ready (rsp_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  always #5 clk = ~clk;

  // A request's memory word is sampled one edge after acceptance (before that edge's write)
  // and becomes visible two edges after acceptance.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        err;
    int          read_cyc;
    int          avail;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
    int          cyc;
  } seen_t;

  exp_t        exp_q[$];
  seen_t       log_q[$];
  logic [31:0] shadow [DEPTH];
  int          cyc;
  int          n_checks;
  int          n_errors;
  int          n_acc;
  int          last_acc_cyc;
  logic        last_acc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic is_oor(input logic [31:0] a);
`ifdef IMEM_OOR_TRAP_EN
    return a >= 32'(DEPTH);
`else
    return 1'b0;
`endif
  endfunction

  // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
  task automatic cycle();
    logic exp_rdy;
    logic exp_vld;
    logic pop;
    @(negedge clk);
    exp_rdy = reset && !flush && (exp_q.size() < FD);
    exp_vld = reset && (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
    check("req_ready", req_ready, exp_rdy);
    check("rsp_valid", rsp_valid, exp_vld);
    if (exp_vld) begin
      check("rsp_instr", rsp_instr, exp_q[0].instr);
      check("rsp_addr", rsp_addr, exp_q[0].addr);
      check("rsp_err", rsp_err, exp_q[0].err);
    end
    last_acc = req_valid && exp_rdy;
    pop      = exp_vld && rsp_ready;
    if (pop) log_q.push_back('{instr: rsp_instr, addr: rsp_addr, err: rsp_err, cyc: cyc});
    @(posedge clk);
    cyc++;
    if (!reset || flush) begin
      exp_q.delete();
    end else begin
      foreach (exp_q[i])
        if (exp_q[i].read_cyc == cyc)
          exp_q[i].instr = exp_q[i].err ? 32'h0 : shadow[exp_q[i].addr[AW-1:0]];
      if (pop) void'(exp_q.pop_front());
      if (last_acc) begin
        exp_q.push_back('{addr: req_addr, instr: 32'h0, err: is_oor(req_addr),
                          read_cyc: cyc + 1, avail: cyc + 2});
        n_acc++;
        last_acc_cyc = cyc;
      end
    end
    if (wr_en) shadow[wr_addr[AW-1:0]] = wr_data;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic request(input logic [31:0] a);
    req_valid = 1'b1;
    req_addr  = a;
    cycle();
    req_valid = 1'b0;
  endtask

  logic [31:0] seq_data [4];
  logic [31:0] pc;
  logic [31:0] exp_w;
  int          a0;
  int          c0;

  initial begin
    n_checks = 0; n_errors = 0; n_acc = 0; cyc = 0; last_acc = 1'b0; last_acc_cyc = 0;
    reset = 1'b0; req_valid = 1'b0; req_addr = '0; flush = 1'b0; rsp_ready = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
    seq_data[0] = 32'h11; seq_data[1] = 32'h22; seq_data[2] = 32'h33; seq_data[3] = 32'h44;

    #2;
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_instr", rsp_instr, 32'h0);
    check("rst_rsp_addr", rsp_addr, 32'h0);
    check("rst_rsp_err", rsp_err, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1 check("ready_after_rst", req_ready, 1'b1);

    // Load the whole memory; upper address bits are junk and must be ignored.
    for (int i = 0; i < DEPTH; i++) begin
      wr_en   = 1'b1;
      wr_addr = ($urandom() & 32'hFFFF_FF00) | 32'(i);
      wr_data = (i < 4) ? seq_data[i] : (i == 5) ? 32'h55 : $urandom();
      cycle();
    end
    wr_en = 1'b0;

    // Back-to-back sequential fetch, latency 2.
    rsp_ready = 1'b1;
    log_q.delete();
    a0 = n_acc;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1;
      req_addr  = 32'(i);
      cycle();
      if (i == 0) c0 = last_acc_cyc;
    end
    req_valid = 1'b0;
    idle(6);
    check("seq_accepts", n_acc - a0, 4);
    check("seq_count", log_q.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < log_q.size()) begin
        check("seq_instr", log_q[i].instr, seq_data[i]);
        check("seq_addr", log_q[i].addr, 32'(i));
        check("seq_latency", log_q[i].cyc, c0 + 2 + i);
      end

    // Backpressure: credits stop acceptance at FIFO_DEPTH.
    rsp_ready = 1'b0;
    a0 = n_acc;
    req_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_addr = 32'd100 + 32'(n_acc - a0);
      cycle();
    end
    req_valid = 1'b0;
    check("fill_accepts", n_acc - a0, FD);
    log_q.delete();
    rsp_ready = 1'b1;
    idle(6);
    check("drain_count", log_q.size(), FD);
    for (int i = 0; i < FD; i++)
      if (i < log_q.size()) check("drain_addr", log_q[i].addr, 32'd100 + 32'(i));

    // Flush discards two in-flight fetches and blocks a concurrent request.
    log_q.delete();
    request(32'd8);
    request(32'd9);
    a0 = n_acc;
    flush = 1'b1; req_valid = 1'b1; req_addr = 32'd10;
    cycle();
    flush = 1'b0; req_valid = 1'b0;
    check("flush_blocks_req", n_acc - a0, 0);
    request(32'd20);
    idle(5);
    check("flush_count", log_q.size(), 1);
    if (log_q.size() > 0) begin
      check("flush_first_addr", log_q[0].addr, 32'd20);
      check("flush_first_instr", log_q[0].instr, shadow[20]);
    end

    // Write to word 5 on the edge that reads it: old data first, new data on refetch.
    log_q.delete();
    request(32'd5);
    wr_en = 1'b1; wr_addr = 32'd5; wr_data = 32'hAA;
    cycle();
    wr_en = 1'b0;
    idle(3);
    request(32'd5);
    idle(4);
    check("rw_count", log_q.size(), 2);
    if (log_q.size() > 1) begin
      check("rw_old", log_q[0].instr, 32'h55);
      check("rw_new", log_q[1].instr, 32'hAA);
    end

    // Out-of-range address.
    log_q.delete();
    request(32'd300);
    idle(4);
`ifdef IMEM_OOR_TRAP_EN
    exp_w = 32'h0;
`else
    exp_w = shadow[44];
`endif
    check("oor_count", log_q.size(), 1);
    if (log_q.size() > 0) begin
      check("oor_instr", log_q[0].instr, exp_w);
      check("oor_err", log_q[0].err, is_oor(32'd300));
    end

    // Full throughput with the consumer always ready.
    a0 = n_acc;
    req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      req_addr = 32'd40 + 32'(n_acc - a0);
      cycle();
    end
    req_valid = 1'b0;
    check("throughput", n_acc - a0, 20);
    idle(4);

    // Reset with three buffered responses.
    rsp_ready = 1'b0;
    request(32'd60); request(32'd61); request(32'd62);
    idle(3);
    check("pre_rst_valid", rsp_valid, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("midrst_valid", rsp_valid, 1'b0);
    check("midrst_ready", req_ready, 1'b0);
    check("midrst_instr", rsp_instr, 32'h0);
    @(posedge clk); #1;
    idle(2);
    reset = 1'b1;
    #1 check("ready_after_rst2", req_ready, 1'b1);
    rsp_ready = 1'b1;
    log_q.delete();
    idle(5);
    check("no_stale_rsp", log_q.size(), 0);

    // Randomized traffic with flushes, backpressure, writes and address wrap.
    pc = 32'd0;
    for (int k = 0; k < 1500; k++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      rsp_ready = ($urandom_range(0, 9) < 7);
      wr_en     = ($urandom_range(0, 9) == 0);
      wr_addr   = $urandom();
      wr_data   = $urandom();
      req_addr  = pc;
      cycle();
      if (flush) pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFD : 32'($urandom_range(0, 400));
      else if (last_acc) pc = pc + 32'd1;
    end
    req_valid = 1'b0; flush = 1'b0; wr_en = 1'b0; rsp_ready = 1'b1;
    idle(8);
    check("final_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
